// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencer for the up-counter datapath.
// Starts, pauses, stops and terminates count runs. Supports one-shot and auto-reload.
// Drives the counter clear/enable and watches its value for the terminal count.
// Optional feature: define COUNTER_SEQ_CTRL_IRQ_EN to add a sticky irq output with an irq_clr input.

module counter_seq_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              auto_reload,
    input  logic [WIDTH-1:0]  tc,
    input  logic [WIDTH-1:0]  cnt_val,
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
    input  logic              irq_clr,
    output logic              irq,
`endif
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [WRAP_W-1:0] WrapMax = '1;

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  tc_q, tc_d;
    logic              ar_q, ar_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              done_q, done_d;
    logic              at_tc;
    logic              term_evt;

    assign at_tc = (cnt_val == tc_q);

    // Next-state logic; priority is stop > pause > terminal detect > start.
    always_comb begin
        state_d  = state_q;
        tc_d     = tc_q;
        ar_d     = ar_q;
        wrap_d   = wrap_q;
        term_evt = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StRun;
                    tc_d    = tc;
                    ar_d    = auto_reload;
                    wrap_d  = '0;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (pause) begin
                    state_d = StHold;
                end else if (at_tc) begin
                    term_evt = 1'b1;
                    state_d  = ar_q ? StRun : StDone;
                end
            end
            StHold: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (!pause) begin
                    state_d = StRun;
                end
            end
            default: begin
                // StDone lasts exactly one cycle.
                state_d = StIdle;
            end
        endcase
        if (term_evt && (wrap_q != WrapMax)) begin
            wrap_d = wrap_q + WRAP_W'(1);
        end
        done_d = term_evt;
    end

    // State and run-parameter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tc_q    <= '0;
            ar_q    <= 1'b0;
            wrap_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            ar_q    <= ar_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    // Counter control decoded from the current state.
    always_comb begin
        cnt_en  = (state_q == StRun) && !pause && !stop;
        // Out-of-range cnt_val in RUN gets no clear; the counter wraps around to tc_q.
        cnt_clr = (state_q == StIdle) || (state_q == StDone) || ((state_q == StRun) && at_tc);
        busy    = (state_q != StIdle);
    end

    assign done     = done_q;
    assign wrap_cnt = wrap_q;

`ifdef COUNTER_SEQ_CTRL_IRQ_EN
    logic irq_q;

    // Sticky interrupt: a done pulse sets it and wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else if (done_q) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

endmodule
